// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX operand and opcode information in, pipeline
// hold/flush/bubble controls plus debug state and performance counters out.
interface hazard_ctrl_if #(
  parameter int XREG_ADDRWIDTH = 5,
  parameter int CNT_WIDTH      = 32
);
  logic [XREG_ADDRWIDTH-1:0] id_rs1_addr;
  logic                      id_rs1_used;
  logic [XREG_ADDRWIDTH-1:0] id_rs2_addr;
  logic                      id_rs2_used;
  logic [6:0]                ex_opcode;
  logic                      ex_rd_en;
  logic [XREG_ADDRWIDTH-1:0] ex_rd_addr;
  logic                      ex_branch_taken;
  logic                      ex_mc_start;
  logic                      ex_mc_done;
  logic                      pc_hold;
  logic                      if_id_hold;
  logic                      if_id_flush;
  logic                      load_hazerd;
  logic                      flush_flag;
  logic                      ex_bubble;
  logic [1:0]                state_out;
  logic [CNT_WIDTH-1:0]      stall_cnt;
  logic [CNT_WIDTH-1:0]      flush_cnt;

  modport master (
    output id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
    output ex_opcode, ex_rd_en, ex_rd_addr, ex_branch_taken, ex_mc_start, ex_mc_done,
    input  pc_hold, if_id_hold, if_id_flush, load_hazerd, flush_flag, ex_bubble,
    input  state_out, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
    input  ex_opcode, ex_rd_en, ex_rd_addr, ex_branch_taken, ex_mc_start, ex_mc_done,
    output pc_hold, if_id_hold, if_id_flush, load_hazerd, flush_flag, ex_bubble,
    output state_out, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flush controller: load-use stalls, multi-cycle EX waits and
// branch flushes, with saturating stall/flush cycle counters.
module hazard_ctrl #(
  parameter int         XREG_ADDRWIDTH = 5,
  parameter logic [6:0] LOAD_OPCODE    = 7'b0000011,
  parameter int         CNT_WIDTH      = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  io_hz
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MC_WAIT    = 2'd2,
    ST_ILLEGAL    = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [XREG_ADDRWIDTH-1:0] REG_ZERO = {XREG_ADDRWIDTH{1'b0}};

  state_t               r_state;
  state_t               w_next;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;
  logic                 w_load_use;
  logic                 w_pc_hold;
  logic                 w_if_id_hold;
  logic                 w_if_id_flush;
  logic                 w_load_hazerd;
  logic                 w_flush_flag;
  logic                 w_ex_bubble;

  assign w_load_use = (io_hz.ex_opcode == LOAD_OPCODE) & io_hz.ex_rd_en &
                      (io_hz.ex_rd_addr != REG_ZERO) &
                      ((io_hz.id_rs1_used & (io_hz.id_rs1_addr == io_hz.ex_rd_addr)) |
                       (io_hz.id_rs2_used & (io_hz.id_rs2_addr == io_hz.ex_rd_addr)));

  // Zero-latency control decode; reset forces every control low.
  always_comb begin
    w_next        = r_state;
    w_pc_hold     = 1'b0;
    w_if_id_hold  = 1'b0;
    w_if_id_flush = 1'b0;
    w_load_hazerd = 1'b0;
    w_flush_flag  = 1'b0;
    w_ex_bubble   = 1'b0;
    if (rst) begin
      w_next = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (io_hz.ex_branch_taken) begin
            w_flush_flag  = 1'b1;
            w_if_id_flush = 1'b1;
            w_next        = ST_RUN;
          end else if (io_hz.ex_mc_start) begin
            // A start with done in the same cycle is a single-cycle op.
            if (io_hz.ex_mc_done) begin
              w_next = ST_RUN;
            end else begin
              w_load_hazerd = 1'b1;
              w_pc_hold     = 1'b1;
              w_if_id_hold  = 1'b1;
              w_ex_bubble   = 1'b1;
              w_next        = ST_MC_WAIT;
            end
          end else if (w_load_use) begin
            w_load_hazerd = 1'b1;
            w_pc_hold     = 1'b1;
            w_if_id_hold  = 1'b1;
            w_next        = ST_LOAD_STALL;
          end else begin
            w_next = ST_RUN;
          end
        end
        ST_LOAD_STALL: begin
          // The held load is still visible in EX; drop the duplicate.
          w_ex_bubble = 1'b1;
          w_next      = ST_RUN;
        end
        ST_MC_WAIT: begin
          if (io_hz.ex_mc_done) begin
            w_next = ST_RUN;
          end else begin
            w_load_hazerd = 1'b1;
            w_pc_hold     = 1'b1;
            w_if_id_hold  = 1'b1;
            w_ex_bubble   = 1'b1;
            w_next        = ST_MC_WAIT;
          end
        end
        default: begin
          w_next = ST_RUN;
        end
      endcase
    end
  end

  // FSM state and saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= {CNT_WIDTH{1'b0}};
      r_flush_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      r_state <= w_next;
      if (w_load_hazerd && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (w_flush_flag && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign io_hz.pc_hold     = w_pc_hold;
  assign io_hz.if_id_hold  = w_if_id_hold;
  assign io_hz.if_id_flush = w_if_id_flush;
  assign io_hz.load_hazerd = w_load_hazerd;
  assign io_hz.flush_flag  = w_flush_flag;
  assign io_hz.ex_bubble   = w_ex_bubble;
  assign io_hz.state_out   = r_state;
  assign io_hz.stall_cnt   = r_stall_cnt;
  assign io_hz.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected controls,
// state and counters; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b110100;  // {pc_hold,if_id_hold,if_id_flush,load_hazerd,flush_flag,ex_bubble}
  localparam logic [5:0] C_MC    = 6'b110101;
  localparam logic [5:0] C_BUB   = 6'b000001;
  localparam logic [5:0] C_FL    = 6'b001010;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  typedef struct {
    string       nm;
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  hazard_ctrl_if #(.XREG_ADDRWIDTH(5), .CNT_WIDTH(32)) hz ();
  hazard_ctrl_if #(.XREG_ADDRWIDTH(5), .CNT_WIDTH(4))  hz4 ();

  hazard_ctrl #(.XREG_ADDRWIDTH(5), .LOAD_OPCODE(7'b0000011), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .io_hz(hz.slave)
  );
  hazard_ctrl #(.XREG_ADDRWIDTH(5), .LOAD_OPCODE(7'b0000011), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .io_hz(hz4.slave)
  );

  assign hz4.id_rs1_addr     = hz.id_rs1_addr;
  assign hz4.id_rs1_used     = hz.id_rs1_used;
  assign hz4.id_rs2_addr     = hz.id_rs2_addr;
  assign hz4.id_rs2_used     = hz.id_rs2_used;
  assign hz4.ex_opcode       = hz.ex_opcode;
  assign hz4.ex_rd_en        = hz.ex_rd_en;
  assign hz4.ex_rd_addr      = hz.ex_rd_addr;
  assign hz4.ex_branch_taken = hz.ex_branch_taken;
  assign hz4.ex_mc_start     = hz.ex_mc_start;
  assign hz4.ex_mc_done      = hz.ex_mc_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks = checks + 1;
    if (act !== exp_v) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
    end
  endtask

  task automatic push_exp(input string nm, input logic [5:0] c, input logic [1:0] s,
                          input logic [31:0] sc_v, input logic [31:0] fc_v);
    exp_t e;
    e.nm  = nm;
    e.ctl = c;
    e.st  = s;
    e.sc  = sc_v;
    e.fc  = fc_v;
    sb.push_back(e);
  endtask

  // Advance one cycle and return all pipeline inputs to an idle pattern.
  task automatic tick();
    @(posedge clk);
    #1;
    hz.id_rs1_addr     = 5'd0;
    hz.id_rs1_used     = 1'b0;
    hz.id_rs2_addr     = 5'd0;
    hz.id_rs2_used     = 1'b0;
    hz.ex_opcode       = 7'd0;
    hz.ex_rd_en        = 1'b0;
    hz.ex_rd_addr      = 5'd0;
    hz.ex_branch_taken = 1'b0;
    hz.ex_mc_start     = 1'b0;
    hz.ex_mc_done      = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs2, input logic rs2u);
    hz.ex_opcode   = OP_LOAD;
    hz.ex_rd_en    = 1'b1;
    hz.ex_rd_addr  = rd;
    hz.id_rs2_addr = rs2;
    hz.id_rs2_used = rs2u;
  endtask

  // Monitor: compare the DUT against the oldest scoreboard entry.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.nm, "_ctl"}, {26'd0, hz.pc_hold, hz.if_id_hold, hz.if_id_flush,
                           hz.load_hazerd, hz.flush_flag, hz.ex_bubble}, {26'd0, e.ctl});
      chk({e.nm, "_state"}, {30'd0, hz.state_out}, {30'd0, e.st});
      chk({e.nm, "_stall_cnt"}, hz.stall_cnt, e.sc);
      chk({e.nm, "_flush_cnt"}, hz.flush_cnt, e.fc);
      chk({e.nm, "_excl"}, {30'd0, hz.flush_flag & hz.load_hazerd, hz.if_id_flush & hz.if_id_hold}, 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    tick();
    hz.ex_mc_start = 1'b1;
    push_exp("in_reset", C_NONE, 2'd0, 32'd0, 32'd0);
    tick(); rst = 1'b0;
    push_exp("idle", C_NONE, 2'd0, 32'd0, 32'd0);

    // Load-use on rs2
    tick(); set_load(5'd5, 5'd5, 1'b1);
    push_exp("lu_T", C_STALL, 2'd0, 32'd0, 32'd0);
    tick(); set_load(5'd5, 5'd5, 1'b1);
    push_exp("lu_T1", C_BUB, 2'd1, 32'd1, 32'd0);
    tick();
    push_exp("lu_T2", C_NONE, 2'd0, 32'd1, 32'd0);

    // No-hazard variants
    tick(); set_load(5'd0, 5'd0, 1'b1);
    push_exp("nh_rd0", C_NONE, 2'd0, 32'd1, 32'd0);
    tick(); set_load(5'd5, 5'd5, 1'b0);
    push_exp("nh_unused", C_NONE, 2'd0, 32'd1, 32'd0);
    tick(); set_load(5'd5, 5'd5, 1'b1); hz.ex_opcode = OP_ALU;
    push_exp("nh_alu", C_NONE, 2'd0, 32'd1, 32'd0);
    tick(); set_load(5'd5, 5'd5, 1'b1); hz.ex_rd_en = 1'b0;
    push_exp("nh_rden", C_NONE, 2'd0, 32'd1, 32'd0);

    // Load-use on rs1
    tick(); set_load(5'd7, 5'd3, 1'b1); hz.id_rs1_used = 1'b1; hz.id_rs1_addr = 5'd7;
    push_exp("lu1_T", C_STALL, 2'd0, 32'd1, 32'd0);
    tick();
    push_exp("lu1_T1", C_BUB, 2'd1, 32'd2, 32'd0);
    tick();
    push_exp("lu1_T2", C_NONE, 2'd0, 32'd2, 32'd0);

    // Branch wins over mc_start and load_use
    tick(); set_load(5'd5, 5'd5, 1'b1); hz.ex_mc_start = 1'b1; hz.ex_branch_taken = 1'b1;
    push_exp("br_prio", C_FL, 2'd0, 32'd2, 32'd0);
    tick();
    push_exp("br_after", C_NONE, 2'd0, 32'd2, 32'd1);

    // Multi-cycle op: start at T, done at T+6, branch ignored at T+3
    tick(); hz.ex_mc_start = 1'b1;
    push_exp("mc_T0", C_MC, 2'd0, 32'd2, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 3) hz.ex_branch_taken = 1'b1;
      push_exp($sformatf("mc_T%0d", i), C_MC, 2'd2, 32'(2 + i), 32'd1);
    end
    tick(); hz.ex_mc_done = 1'b1;
    push_exp("mc_T6", C_NONE, 2'd2, 32'd8, 32'd1);
    tick();
    push_exp("mc_T7", C_NONE, 2'd0, 32'd8, 32'd1);

    // Single-cycle op: start and done together
    tick(); hz.ex_mc_start = 1'b1; hz.ex_mc_done = 1'b1;
    push_exp("mc_1cyc", C_NONE, 2'd0, 32'd8, 32'd1);
    tick();
    push_exp("mc_1cyc_after", C_NONE, 2'd0, 32'd8, 32'd1);

    // Reset in the middle of MC_WAIT
    tick(); hz.ex_mc_start = 1'b1;
    push_exp("rmc_start", C_MC, 2'd0, 32'd8, 32'd1);
    tick(); rst = 1'b1;
    push_exp("rmc_reset", C_NONE, 2'd0, 32'd0, 32'd0);
    tick(); rst = 1'b0;
    push_exp("rmc_after", C_NONE, 2'd0, 32'd0, 32'd0);

    // 20 stall cycles: 4-bit counter saturates, 32-bit one keeps counting
    tick(); hz.ex_mc_start = 1'b1;
    push_exp("sat_T0", C_MC, 2'd0, 32'd0, 32'd0);
    for (int i = 1; i <= 19; i++) begin
      tick();
      push_exp($sformatf("sat_T%0d", i), C_MC, 2'd2, 32'(i), 32'd0);
    end
    tick(); hz.ex_mc_done = 1'b1;
    push_exp("sat_done", C_NONE, 2'd2, 32'd20, 32'd0);
    tick();
    push_exp("sat_after", C_NONE, 2'd0, 32'd20, 32'd0);

    @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (sb.size() > 0) @(negedge clk);
    end
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("sat4_stall_cnt", {28'd0, hz4.stall_cnt}, 32'hF);
    chk("sat4_flush_cnt", {28'd0, hz4.flush_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and flush controller for the 5-stage RISC-V core.
- Produces the load_hazerd and flush_flag controls consumed by the ID/EX register.
- Produces matching hold and flush controls for the PC and the IF/ID register, and a bubble request for EX/MEM.
- Small FSM sequences load-use stalls and multi-cycle EX operations (divider); counts stall and flush cycles for performance monitoring.

Parameters:
XREG_ADDRWIDTH, 5, register-file address width
LOAD_OPCODE, 7'b0000011, RV32I load opcode
CNT_WIDTH, 32, width of the performance counters

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous reset, active-high (`RST_ENABLE)
id_rs1_addr  input  XREG_ADDRWIDTH  rs1 index of the instruction in ID
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_addr  input  XREG_ADDRWIDTH  rs2 index of the instruction in ID
id_rs2_used  input  1  ID instruction reads rs2
ex_opcode  input  7  opcode at the ID/EX output
ex_rd_en  input  1  rd write enable at the ID/EX output
ex_rd_addr  input  XREG_ADDRWIDTH  rd at the ID/EX output
ex_branch_taken  input  1  EX resolved a taken branch or jump (redirect)
ex_mc_start  input  1  one-cycle pulse: multi-cycle op started in EX
ex_mc_done  input  1  one-cycle pulse: multi-cycle op result valid
pc_hold  output  1  PC keeps its value
if_id_hold  output  1  IF/ID keeps its contents
if_id_flush  output  1  IF/ID loads a NOP
load_hazerd  output  1  ID/EX holds its contents
flush_flag  output  1  ID/EX clears to zero
ex_bubble  output  1  EX/MEM captures a bubble (rd_en=0, no memory access)
state_out  output  2  current FSM state (debug)
stall_cnt  output  CNT_WIDTH  cycles in which load_hazerd was high
flush_cnt  output  CNT_WIDTH  cycles in which flush_flag was high

Behaviour:
- FSM states: RUN=2'd0, LOAD_STALL=2'd1, MC_WAIT=2'd2. Encoding 2'd3 is illegal and returns to RUN on the next edge.
- Control outputs are combinational from state and inputs, with zero added latency.
- FSM state and counters are registered.
- While rst is high:
  - state=RUN, stall_cnt=0, flush_cnt=0.
  - All six control outputs are forced to 0.
  - A reset mid-stall or mid-MC_WAIT aborts immediately; no residual hold after rst falls.
- load_use definition: (ex_opcode==LOAD_OPCODE) & ex_rd_en & (ex_rd_addr!=0) & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
- RUN, priority order:
  1. ex_branch_taken: flush_flag=1, if_id_flush=1, all holds 0. Next state RUN. Any simultaneous ex_mc_start or load_use is ignored.
  2. ex_mc_start: load_hazerd=1, pc_hold=1, if_id_hold=1, ex_bubble=1. Next state MC_WAIT. If ex_mc_done is in the same cycle, treat it as a one-cycle op: no holds, stay RUN.
  3. load_use: load_hazerd=1, pc_hold=1, if_id_hold=1. Next state LOAD_STALL.
  4. Otherwise all outputs are 0.
- LOAD_STALL, exactly one cycle:
  - ID/EX still shows the held load, so load_use is not re-evaluated.
  - Outputs: ex_bubble=1, all other outputs 0. The duplicated load in EX is dropped.
  - Next state RUN unconditionally.
- MC_WAIT:
  - While ex_mc_done=0: load_hazerd=1, pc_hold=1, if_id_hold=1, ex_bubble=1.
  - ex_branch_taken and ex_mc_start are ignored.
  - When ex_mc_done=1: all outputs 0 and next state RUN. The result is captured by EX/MEM that edge.
  - No timeout; the FSM waits indefinitely.
- flush_flag and load_hazerd are never both 1. if_id_flush and if_id_hold are never both 1.
- Counters:
  - Each increments by 1 per rising edge on which its qualifying output is 1.
  - Each saturates at all-ones and does not wrap.

Test Plan:
- Reset then idle: after rst pulse mid-MC_WAIT, next cycle state_out=0, all controls 0, stall_cnt=flush_cnt=0.
- Load-use: ex_opcode=0000011, ex_rd_en=1, ex_rd_addr=5, id_rs2_used=1, id_rs2_addr=5 -> cycle T load_hazerd=pc_hold=if_id_hold=1. T+1: ex_bubble=1 only, inputs unchanged. T+2: all 0. stall_cnt=1.
- No-hazard cases: same as above with ex_rd_addr=0, or id_rs2_used=0, or ex_opcode=0110011 -> no stall, state stays 0.
- Branch priority: ex_branch_taken=1 with load_use and ex_mc_start also true -> flush_flag=if_id_flush=1, holds 0, state stays RUN. flush_cnt=1.
- Multi-cycle: ex_mc_start at T, ex_mc_done at T+6 -> load_hazerd=1 and ex_bubble=1 for T..T+5, 0 at T+6. stall_cnt=6. ex_branch_taken pulsed at T+3 has no effect.
- Saturation: force counter near max (or CNT_WIDTH=4 build), drive 20 stall cycles -> stall_cnt holds at 4'hF.
